// File: rtl/mem_access_unit.sv
// Load/store alignment unit: byte-lane extract/extend and read-modify-write merge.
// Optional misaligned-access rejection enabled by defining MAU_MISALIGN_CHECK_EN.
module mem_access_unit #(
  parameter logic BIG_ENDIAN = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_signed,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misalign_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] old_q, old_d;
  logic [1:0]  size_q, size_d;

  logic        req_st;
  logic        req_ld;
  logic        mis;
  logic        mis_err;
  logic        we_c;
  logic        stall_c;
  logic        merr_c;
  logic [31:0] rd_c;

  function automatic logic [4:0] byte_sh(input logic [1:0] a);
    return {a ^ {2{BIG_ENDIAN}}, 3'b000};
  endfunction

  function automatic logic [4:0] half_sh(input logic [1:0] a);
    return {a[1] ^ BIG_ENDIAN, 4'b0000};
  endfunction

  function automatic logic [31:0] extract(
    input logic [31:0] w,
    input logic [1:0]  sz,
    input logic [1:0]  a,
    input logic        sgn
  );
    logic [31:0] sb;
    logic [31:0] sh;
    sb = w >> byte_sh(a);
    sh = w >> half_sh(a);
    unique case (sz)
      2'b00:   return {{24{sgn & sb[7]}}, sb[7:0]};
      2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
      default: return w;
    endcase
  endfunction

  // Old word with only the addressed lane(s) replaced by store data.
  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  sz,
    input logic [1:0]  a
  );
    logic [31:0] m;
    logic [31:0] d;
    unique case (sz)
      2'b00: begin
        m = 32'h0000_00ff << byte_sh(a);
        d = {24'h0, wd[7:0]} << byte_sh(a);
      end
      2'b01: begin
        m = 32'h0000_ffff << half_sh(a);
        d = {16'h0, wd[15:0]} << half_sh(a);
      end
      default: begin
        m = 32'hffff_ffff;
        d = wd;
      end
    endcase
    return (old & ~m) | (d & m);
  endfunction

  always_comb begin
    req_st = mem_write;
    req_ld = mem_read & ~mem_write;
    mis    = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    mis = ((size == 2'b01) & address[0]) |
          (size[1] & (|address[1:0]));
`else
    mis = 1'b0;
`endif
    mis_err = (req_st | req_ld) & mis;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    old_d      = old_q;
    size_d     = size_q;
    dmem_addr  = {address[31:2], 2'b00};
    dmem_wdata = write_data;
    we_c       = 1'b0;
    stall_c    = 1'b0;
    merr_c     = 1'b0;
    rd_c       = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (mis_err) begin
          merr_c = 1'b1;
        end else if (req_st) begin
          if (size[1]) begin
            we_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = MERGE;
            addr_d  = address;
            wdat_d  = write_data;
            old_d   = dmem_rdata;
            size_d  = size;
          end
        end else if (req_ld) begin
          rd_c = extract(dmem_rdata, size, address[1:0], load_signed);
        end
      end
      MERGE: begin
        dmem_addr  = {addr_q[31:2], 2'b00};
        dmem_wdata = merge(old_q, wdat_q, size_q, addr_q[1:0]);
        we_c       = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // Reset silences the memory side immediately, aborting an in-flight merge.
  always_comb begin
    dmem_we      = we_c & ~reset;
    stall        = stall_c & ~reset;
    misalign_err = merr_c & ~reset;
    read_data    = reset ? 32'h0 : rd_c;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdat_q  <= 32'h0;
      old_q   <= 32'h0;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      old_q   <= old_d;
      size_q  <= size_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a falling-edge word memory
// and an independent byte-array reference model (little-endian build).
module tb_mem_access_unit;

  logic        clock;
  logic        reset;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_signed;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic [31:0] read_data;
  logic        stall;
  logic        misalign_err;

  logic [31:0] mem [0:63];
  logic [7:0]  rb  [0:255];
  logic [31:0] sb_q [$];
  int          n_vec;
  int          n_err;

  mem_access_unit #(.BIG_ENDIAN(1'b0)) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_data   (write_data),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .size         (size),
    .load_signed  (load_signed),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_we      (dmem_we),
    .dmem_rdata   (dmem_rdata),
    .read_data    (read_data),
    .stall        (stall),
    .misalign_err (misalign_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dmem_rdata = mem[dmem_addr[7:2]];

  always @(negedge clock)
    if (dmem_we) mem[dmem_addr[7:2]] <= dmem_wdata;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int w;
    w = int'(a[7:0]) & ~3;
    return {rb[w+3], rb[w+2], rb[w+1], rb[w]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic sg);
    int b;
    int h;
    logic [7:0]  v8;
    logic [15:0] v16;
    b = int'(a[7:0]);
    h = b & ~1;
    v8 = rb[b];
    v16 = {rb[h+1], rb[h]};
    if (sz == 2'b00) return sg ? {{24{v8[7]}}, v8} : {24'h0, v8};
    if (sz == 2'b01) return sg ? {{16{v16[15]}}, v16} : {16'h0, v16};
    return ref_word(a);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    int b;
    b = int'(a[7:0]);
    if (sz == 2'b00) begin
      rb[b] = wd[7:0];
    end else if (sz == 2'b01) begin
      rb[b & ~1]       = wd[7:0];
      rb[(b & ~1) + 1] = wd[15:8];
    end else begin
      for (int i = 0; i < 4; i++) rb[(b & ~3) + i] = wd[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[7:2]] = v;
    for (int i = 0; i < 4; i++) rb[(int'(a[7:0]) & ~3) + i] = v[8*i +: 8];
  endtask

  task automatic idle_inputs();
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    address     = 32'h0;
    write_data  = 32'h0;
    size        = 2'b00;
    load_signed = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd);
    logic st;
    logic ld;
    logic mis;
    logic [31:0] exp;
    st  = wr;
    ld  = rd & ~wr;
    mis = 1'b0;
`ifdef MAU_MISALIGN_CHECK_EN
    mis = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
`endif
    mis = mis & (rd | wr);
    address     = a;
    write_data  = wd;
    mem_read    = rd;
    mem_write   = wr;
    size        = sz;
    load_signed = sg;
    if (mis) begin
      sb_q.push_back(32'h0);
    end else if (st) begin
      ref_store(a, sz, wd);
      sb_q.push_back(ref_word(a));
    end else if (ld) begin
      sb_q.push_back(ref_load(a, sz, sg));
    end else begin
      sb_q.push_back(32'h0);
    end
    @(negedge clock);
    chk("addr", dmem_addr, {a[31:2], 2'b00});
    chk("merr", {31'h0, misalign_err}, {31'h0, mis});
    if (mis) begin
      exp = sb_q.pop_front();
      chk("mis_we", {31'h0, dmem_we}, 32'h0);
      chk("mis_stall", {31'h0, stall}, 32'h0);
      chk("mis_rd", read_data, exp);
    end else if (st && !sz[1]) begin
      chk("sub_stall", {31'h0, stall}, 32'h1);
      chk("sub_we0", {31'h0, dmem_we}, 32'h0);
      chk("sub_rd0", read_data, 32'h0);
      @(posedge clock);
      #1;
      @(negedge clock);
      exp = sb_q.pop_front();
      chk("mrg_stall", {31'h0, stall}, 32'h0);
      chk("mrg_we", {31'h0, dmem_we}, 32'h1);
      chk("mrg_addr", dmem_addr, {a[31:2], 2'b00});
      chk("mrg_wdata", dmem_wdata, exp);
      chk("mrg_rd0", read_data, 32'h0);
    end else if (st) begin
      exp = sb_q.pop_front();
      chk("wst_we", {31'h0, dmem_we}, 32'h1);
      chk("wst_stall", {31'h0, stall}, 32'h0);
      chk("wst_wdata", dmem_wdata, exp);
      chk("wst_rd0", read_data, 32'h0);
    end else if (ld) begin
      exp = sb_q.pop_front();
      chk("ld_data", read_data, exp);
      chk("ld_we", {31'h0, dmem_we}, 32'h0);
      chk("ld_stall", {31'h0, stall}, 32'h0);
    end else begin
      exp = sb_q.pop_front();
      chk("nop_rd", read_data, exp);
      chk("nop_we", {31'h0, dmem_we}, 32'h0);
      chk("nop_stall", {31'h0, stall}, 32'h0);
    end
    @(posedge clock);
    #1;
    idle_inputs();
    chk("mem", mem[a[7:2]], ref_word(a));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rw;
    logic [1:0]  rs;
    logic [1:0]  op;
    logic        rsg;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    for (int i = 0; i < 256; i++) rb[i] = 8'h0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_we", {31'h0, dmem_we}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_merr", {31'h0, misalign_err}, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rd", read_data, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    @(posedge clock);
    #1;

    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    preload(32'h20, 32'h11223344);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB);
    chk("byte_merge", mem[8], 32'h1122AB44);

    preload(32'h30, 32'h0000F080);
    access(1'b1, 1'b0, 2'b00, 1'b1, 32'h30, 32'h0);
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h30, 32'h0);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    access(1'b1, 1'b0, 2'b11, 1'b1, 32'h30, 32'h0);

    preload(32'h40, 32'h55667788);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h41, 32'h0000CAFE);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h00001234);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h47, 32'h000000EE);

    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h50, 32'h00000005);
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);

    preload(32'h60, 32'hA5A5A5A5);
    address    = 32'h61;
    write_data = 32'h0000003C;
    mem_write  = 1'b1;
    size       = 2'b00;
    @(negedge clock);
    chk("abort_stall", {31'h0, stall}, 32'h1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_we", {31'h0, dmem_we}, 32'h0);
    chk("abort_stall0", {31'h0, stall}, 32'h0);
    @(posedge clock);
    #1;
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    chk("abort_we2", {31'h0, dmem_we}, 32'h0);
    @(posedge clock);
    #1;
    chk("abort_mem", mem[24], 32'hA5A5A5A5);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'h0);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h62, 32'h00000011);

    for (int k = 0; k < 30; k++) begin
      ra  = 32'($urandom_range(0, 255));
      rw  = $urandom;
      rs  = 2'($urandom_range(0, 3));
      op  = 2'($urandom_range(0, 3));
      rsg = 1'($urandom_range(0, 1));
      access(op[0], op[1], rs, rsg, ra, rw);
    end

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
